// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and FSM state type for the fetch stage
package fetch_pkg;
  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from a combinational instruction memory and
// holds one fetched word in a valid/ready slot for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int IMEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               fault,
  output logic [PC_W-1:0]    fault_pc,
  output logic [31:0]        fetch_count
);
  localparam logic [PC_W-1:0] LIMIT = PC_W'(IMEM_WORDS) << 2;
  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic advance, hs, redir, mis, oor, fetch;
  assign imem_addr = pc_q;
  always_comb begin
    advance = !out_valid || out_ready;
    hs = out_valid && out_ready;
    redir = redirect_valid && state_q != FAULT;
    mis = redir && redirect_pc[1:0] != 2'b00;
    oor = state_q == RUN && !redirect_valid && advance && pc_q >= LIMIT;
    fetch = state_q == RUN && !redirect_valid && advance && !oor;
    state_d = (mis || oor) ? FAULT : (redir || state_q == IDLE) ? RUN : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  // A redirect always flushes the slot; otherwise it holds only while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      out_valid <= 1'b0;
      out_pc <= '0;
      out_instr <= '0;
      fault <= 1'b0;
      fault_pc <= '0;
      fetch_count <= '0;
    end else begin
      if (hs) fetch_count <= fetch_count + 32'd1;
      if (mis || oor) begin
        fault <= 1'b1;
        fault_pc <= mis ? redirect_pc : pc_q;
      end
      if (redir && !mis) pc_q <= redirect_pc;
      else if (fetch) pc_q <= pc_q + PC_W'(4);
      if (fetch) begin
        out_pc <= pc_q;
        out_instr <= imem_instr;
      end
      out_valid <= fetch || (out_valid && !out_ready && !redirect_valid && state_q == RUN);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, backpressure, redirect, faults and reset
module tb_fetch_unit;
  logic clk = 0, reset = 1, r2 = 1;
  logic [63:0] addr, rpc, pc, fpc, b_addr, b_pc, b_fpc;
  logic [31:0] instr, oinstr, cnt, b_instr, b_oinstr, b_cnt;
  logic rv = 0, valid, ready = 1, flt, b_valid, b_ready = 1, b_flt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] instr_at(input logic [63:0] a);
    return a == 64'd0 ? 32'h11 : a == 64'd4 ? 32'h22 : a == 64'd8 ? 32'h33 : {16'hA5A5, a[15:0]};
  endfunction
  assign instr = instr_at(addr);
  assign b_instr = instr_at(b_addr);
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(addr), .imem_instr(instr),
    .redirect_valid(rv), .redirect_pc(rpc), .out_valid(valid), .out_ready(ready),
    .out_pc(pc), .out_instr(oinstr), .fault(flt), .fault_pc(fpc), .fetch_count(cnt)
  );
  fetch_unit #(.IMEM_WORDS(4)) dut4 (
    .clk(clk), .reset(r2), .imem_addr(b_addr), .imem_instr(b_instr),
    .redirect_valid(1'b0), .redirect_pc(64'd0), .out_valid(b_valid), .out_ready(b_ready),
    .out_pc(b_pc), .out_instr(b_oinstr), .fault(b_flt), .fault_pc(b_fpc), .fetch_count(b_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rpc = 0;
    repeat (2) step();
    chk("rst_valid", 64'(valid), 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", 64'(oinstr), 0);
    chk("rst_fault", 64'(flt), 0);
    chk("rst_fpc", fpc, 0);
    chk("rst_cnt", 64'(cnt), 0);
    chk("rst_addr", addr, 0);
    reset = 0;
    step();
    chk("idle_valid", 64'(valid), 0);
    step();
    chk("f0_valid", 64'(valid), 1);
    chk("f0_pc", pc, 0);
    chk("f0_instr", 64'(oinstr), 32'h11);
    chk("f0_addr", addr, 4);
    step();
    chk("f1_pc", pc, 4);
    chk("f1_instr", 64'(oinstr), 32'h22);
    chk("f1_cnt", 64'(cnt), 1);
    step();
    chk("f2_pc", pc, 8);
    chk("f2_instr", 64'(oinstr), 32'h33);
    step();
    chk("f3_cnt", 64'(cnt), 3);
    chk("f3_pc", pc, 12);
    repeat (2) step();
    chk("pre_rst_cnt", 64'(cnt), 5);
    chk("pre_rst_valid", 64'(valid), 1);
    #1 reset = 1;
    #1;
    chk("arst_valid", 64'(valid), 0);
    chk("arst_cnt", 64'(cnt), 0);
    chk("arst_addr", addr, 0);
    repeat (2) step();
    reset = 0;
    step();
    step();
    chk("re_valid", 64'(valid), 1);
    chk("re_pc", pc, 0);
    step();
    chk("re1_pc", pc, 4);
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 64'(valid), 1);
      chk("bp_pc", pc, 4);
      chk("bp_instr", 64'(oinstr), 32'h22);
      chk("bp_addr", addr, 8);
      chk("bp_cnt", 64'(cnt), 1);
    end
    ready = 1;
    step();
    chk("bp_rel_pc", pc, 8);
    chk("bp_rel_cnt", 64'(cnt), 2);
    ready = 0;
    step();
    chk("hold8_pc", pc, 8);
    rv = 1;
    rpc = 64'h40;
    step();
    chk("rd_flush", 64'(valid), 0);
    chk("rd_cnt", 64'(cnt), 2);
    chk("rd_addr", addr, 64'h40);
    rv = 0;
    step();
    chk("rd_tgt_valid", 64'(valid), 1);
    chk("rd_tgt_pc", pc, 64'h40);
    chk("rd_tgt_instr", 64'(oinstr), 32'hA5A5_0040);
    chk("rd_tgt_cnt", 64'(cnt), 2);
    ready = 1;
    rv = 1;
    rpc = 64'h80;
    step();
    chk("rdhs_valid", 64'(valid), 0);
    chk("rdhs_cnt", 64'(cnt), 3);
    rv = 0;
    step();
    chk("rdhs_pc", pc, 64'h80);
    ready = 0;
    rv = 1;
    rpc = 64'h42;
    step();
    chk("mis_fault", 64'(flt), 1);
    chk("mis_fpc", fpc, 64'h42);
    chk("mis_valid", 64'(valid), 0);
    chk("mis_addr", addr, 64'h84);
    rpc = 0;
    ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flt_fault", 64'(flt), 1);
      chk("flt_fpc", fpc, 64'h42);
      chk("flt_valid", 64'(valid), 0);
      chk("flt_addr", addr, 64'h84);
      chk("flt_cnt", 64'(cnt), 3);
    end
    rv = 0;
    r2 = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_valid", 64'(b_valid), 1);
      chk("seq_pc", b_pc, 64'(4 * i));
    end
    chk("seq_cnt", 64'(b_cnt), 3);
    step();
    chk("oor_fault", 64'(b_flt), 1);
    chk("oor_fpc", b_fpc, 16);
    chk("oor_valid", 64'(b_valid), 0);
    chk("oor_cnt", 64'(b_cnt), 4);
    repeat (2) step();
    chk("oor_hold_valid", 64'(b_valid), 0);
    chk("oor_hold_cnt", 64'(b_cnt), 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
